// File: rtl/key_bounce_gen.sv
// key_bounce_gen: emulated active-low push-button with LFSR-timed contact bounce
// on press and release, one press/release event per accepted start.
module key_bounce_gen #(
  parameter int unsigned BOUNCE_LEN = 9_999,
  parameter int unsigned HOLD_LEN   = 1_999_999,
  parameter int unsigned GAP_LEN    = 999_999,
  parameter int          TOG_W      = 4,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic start,
  output logic key_out,
  output logic busy,
  output logic done
);
  localparam int unsigned MX = (HOLD_LEN > GAP_LEN) ? HOLD_LEN : GAP_LEN;
  localparam int CW = (MX > 32'd1_048_576) ? $clog2(MX) : 20;
  localparam logic [15:0] SEED0 = (SEED == 16'h0) ? 16'hACE1 : SEED;
  localparam logic [CW-1:0] B1 = CW'(BOUNCE_LEN - 1);
  localparam logic [CW-1:0] H1 = CW'(HOLD_LEN - 1);
  localparam logic [CW-1:0] G1 = CW'(GAP_LEN - 1);
  typedef enum logic [2:0] {IDLE, PRESS_BNC, HOLD, REL_BNC, GAP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TOG_W-1:0] tmr_q, tmr_d;
  logic [15:0] lfsr_q;
  logic key_q, key_d, busy_q, busy_d, done_q, done_d;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tmr_q   <= '0;
      lfsr_q  <= SEED0;
      key_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      lfsr_q  <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      key_q   <= key_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    key_d   = key_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        key_d = 1'b1;
        if (start) begin
          state_d = PRESS_BNC;
          key_d   = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          tmr_d   = lfsr_q[TOG_W-1:0];
        end
      end
      PRESS_BNC, REL_BNC: begin
        // the last bounce cycle settles to the phase's final level, overriding any toggle
        if (cnt_q == B1) begin
          state_d = (state_q == PRESS_BNC) ? HOLD : GAP;
          key_d   = (state_q == REL_BNC);
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          key_d = (tmr_q == '0) ? ~key_q : key_q;
          tmr_d = (tmr_q == '0) ? lfsr_q[TOG_W-1:0] : tmr_q - 1'b1;
        end
      end
      HOLD: begin
        key_d = 1'b0;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == H1) begin
          state_d = REL_BNC;
          key_d   = 1'b1;
          cnt_d   = '0;
          tmr_d   = lfsr_q[TOG_W-1:0];
        end
      end
      GAP: begin
        key_d = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == G1) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign key_out = key_q;
  assign busy    = busy_q;
  assign done    = done_q;
endmodule
